// File: rtl/mic_sample_ram_writer.sv
// Packs pairs of mic samples into 32-bit words and writes them to a two-half
// ping-pong region of the sample RAM, flagging each completed half to the CPU.
module mic_sample_ram_writer #(
   parameter int ADDR_WIDTH   = 9,
   parameter int SAMPLE_WIDTH = 16
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_enable,
   input  logic                      i_sample_valid,
   input  logic [SAMPLE_WIDTH-1:0]   i_sample_data,
   input  logic [1:0]                i_ack,
   input  logic                      i_clear_overrun,
   output logic [ADDR_WIDTH-1:0]     o_ram_address,
   output logic [2*SAMPLE_WIDTH-1:0] o_ram_writedata,
   output logic [3:0]                o_ram_byteenable,
   output logic                      o_ram_chipselect,
   output logic                      o_ram_write,
   output logic                      o_ram_clken,
   output logic [1:0]                o_buf_full,
   output logic                      o_irq,
   output logic                      o_overrun,
   output logic                      o_active_half
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam int HALF_MSB = ADDR_WIDTH - 1;

   state_t                  r_state;
   logic                    r_phase_high;
   logic [SAMPLE_WIDTH-1:0] r_held_low;
   logic [ADDR_WIDTH-1:0]   r_ptr;

   logic       w_half;
   logic       w_last_in_half;
   logic       w_target_full;
   logic       w_word_issue;
   logic       w_flush_issue;
   logic       w_drop;
   logic [1:0] w_set_full;

   // Decode this cycle's write attempt and its effect on the status flags.
   always_comb begin
      w_half         = r_ptr[HALF_MSB];
      w_last_in_half = &r_ptr[HALF_MSB-1:0];
      w_target_full  = o_buf_full[w_half];
      w_word_issue   = 1'b0;
      w_flush_issue  = 1'b0;
      w_set_full     = 2'b00;
      if ((r_state == FILL) && i_enable && i_sample_valid && r_phase_high) begin
         w_word_issue = 1'b1;
      end else if (r_state == FLUSH) begin
         w_flush_issue = 1'b1;
      end else begin
         w_word_issue  = 1'b0;
         w_flush_issue = 1'b0;
      end
      w_drop = (w_word_issue | w_flush_issue) & w_target_full;
      if (w_word_issue && !w_target_full && w_last_in_half) begin
         w_set_full = w_half ? 2'b10 : 2'b01;
      end else begin
         w_set_full = 2'b00;
      end
   end

   // Capture FSM, pointer management and registered RAM/status outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state          <= IDLE;
         r_phase_high     <= 1'b0;
         r_held_low       <= {SAMPLE_WIDTH{1'b0}};
         r_ptr            <= {ADDR_WIDTH{1'b0}};
         o_ram_address    <= {ADDR_WIDTH{1'b0}};
         o_ram_writedata  <= {(2*SAMPLE_WIDTH){1'b0}};
         o_ram_byteenable <= 4'b0000;
         o_ram_chipselect <= 1'b0;
         o_ram_write      <= 1'b0;
         o_ram_clken      <= 1'b1;
         o_buf_full       <= 2'b00;
         o_irq            <= 1'b0;
         o_overrun        <= 1'b0;
         o_active_half    <= 1'b0;
      end else begin
         o_ram_clken      <= 1'b1;
         o_ram_chipselect <= 1'b0;
         o_ram_write      <= 1'b0;
         o_ram_byteenable <= 4'b0000;
         // A set in the same cycle as its ack wins.
         o_buf_full       <= (o_buf_full & ~i_ack) | w_set_full;
         o_irq            <= |o_buf_full;
         o_overrun        <= (o_overrun & ~i_clear_overrun) | w_drop;

         case (r_state)
            IDLE: begin
               r_phase_high <= 1'b0;
               if (i_enable) begin
                  r_state <= FILL;
               end else begin
                  r_state <= IDLE;
               end
            end
            FILL: begin
               if (!i_enable) begin
                  r_state <= r_phase_high ? FLUSH : IDLE;
               end else if (i_sample_valid && !r_phase_high) begin
                  r_held_low   <= i_sample_data;
                  r_phase_high <= 1'b1;
               end else if (i_sample_valid) begin
                  r_phase_high <= 1'b0;
                  if (!w_target_full) begin
                     o_ram_chipselect <= 1'b1;
                     o_ram_write      <= 1'b1;
                     o_ram_byteenable <= 4'b1111;
                     o_ram_address    <= r_ptr;
                     o_ram_writedata  <= {i_sample_data, r_held_low};
                     if (w_last_in_half) begin
                        r_ptr         <= {~w_half, {(ADDR_WIDTH-1){1'b0}}};
                        o_active_half <= ~w_half;
                     end else begin
                        r_ptr <= r_ptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                     end
                  end else begin
                     r_ptr <= r_ptr;
                  end
               end else begin
                  r_state <= FILL;
               end
            end
            FLUSH: begin
               r_phase_high <= 1'b0;
               r_state      <= IDLE;
               // Partial word: only the low half carries data; pointer stays put.
               if (!w_target_full) begin
                  o_ram_chipselect <= 1'b1;
                  o_ram_write      <= 1'b1;
                  o_ram_byteenable <= 4'b0011;
                  o_ram_address    <= r_ptr;
                  o_ram_writedata  <= {{SAMPLE_WIDTH{1'b0}}, r_held_low};
               end else begin
                  r_ptr <= r_ptr;
               end
            end
            default: begin
               r_state      <= IDLE;
               r_phase_high <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mic_sample_ram_writer.sv
// Directed self-checking bench for mic_sample_ram_writer.
module tb_mic_sample_ram_writer;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        sample_valid;
   logic [15:0] sample_data;
   logic [1:0]  ack;
   logic        clear_overrun;
   logic [8:0]  ram_address;
   logic [31:0] ram_writedata;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect;
   logic        ram_write;
   logic        ram_clken;
   logic [1:0]  buf_full;
   logic        irq;
   logic        overrun;
   logic        active_half;

   int n_checks;
   int n_fails;

   mic_sample_ram_writer dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_enable         (enable),
      .i_sample_valid   (sample_valid),
      .i_sample_data    (sample_data),
      .i_ack            (ack),
      .i_clear_overrun  (clear_overrun),
      .o_ram_address    (ram_address),
      .o_ram_writedata  (ram_writedata),
      .o_ram_byteenable (ram_byteenable),
      .o_ram_chipselect (ram_chipselect),
      .o_ram_write      (ram_write),
      .o_ram_clken      (ram_clken),
      .o_buf_full       (buf_full),
      .o_irq            (irq),
      .o_overrun        (overrun),
      .o_active_half    (active_half)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_sample(input logic [15:0] d);
      sample_valid = 1'b1;
      sample_data  = d;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk_eq({tag, "_addr"}, {23'd0, ram_address}, 32'd0);
      chk_eq({tag, "_wdata"}, ram_writedata, 32'd0);
      chk_eq({tag, "_strobes"}, {25'd0, ram_byteenable, ram_chipselect, ram_write, ram_clken}, 32'h0000_0001);
      chk_eq({tag, "_status"}, {27'd0, buf_full, irq, overrun, active_half}, 32'd0);
   endtask

   // Write words first..last with a pattern derived from the word index.
   task automatic fill_words(input string tag, input int first, input int last);
      int good;
      logic [15:0] lo;
      logic [15:0] hi;
      good = 0;
      for (int w = first; w <= last; w++) begin
         lo = 16'h5A00 ^ 16'(w);
         hi = ~(16'(w));
         send_sample(lo);
         send_sample(hi);
         if (ram_write === 1'b1 && ram_address === 9'(w) && ram_writedata === {hi, lo})
            good++;
      end
      chk_eq(tag, 32'(good), 32'(last - first + 1));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      n_checks      = 0;
      n_fails       = 0;
      reset         = 1'b0;
      enable        = 1'b0;
      sample_valid  = 1'b0;
      sample_data   = 16'h0000;
      ack           = 2'b00;
      clear_overrun = 1'b0;

      do_reset();
      check_reset_outputs("reset");

      // First word
      enable = 1'b1;
      tick();
      send_sample(16'h0001);
      chk_eq("first_no_write_yet", {31'd0, ram_write}, 32'd0);
      send_sample(16'h0002);
      chk_eq("first_strobes", {27'd0, ram_byteenable, ram_chipselect}, {27'd0, 4'hF, 1'b1});
      chk_eq("first_write", {31'd0, ram_write}, 32'd1);
      chk_eq("first_addr", {23'd0, ram_address}, 32'd0);
      chk_eq("first_data", ram_writedata, 32'h0002_0001);
      tick();
      chk_eq("write_one_cycle", {31'd0, ram_write}, 32'd0);
      chk_eq("addr_holds", {23'd0, ram_address}, 32'd0);
      chk_eq("data_holds", ram_writedata, 32'h0002_0001);

      // Complete half 0
      fill_words("fill_half0", 1, 255);
      chk_eq("half0_last_addr", {23'd0, ram_address}, 32'd255);
      chk_eq("half0_full", {30'd0, buf_full}, 32'd1);
      chk_eq("half0_irq_lag", {31'd0, irq}, 32'd0);
      chk_eq("half0_active", {31'd0, active_half}, 32'd1);
      tick();
      chk_eq("half0_irq", {31'd0, irq}, 32'd1);
      fill_words("first_word_half1", 256, 256);

      // Complete half 1, then overrun
      fill_words("fill_half1", 257, 511);
      chk_eq("both_full", {30'd0, buf_full}, 32'd3);
      chk_eq("wrap_active", {31'd0, active_half}, 32'd0);
      send_sample(16'h1234);
      send_sample(16'h5678);
      chk_eq("drop_no_write", {31'd0, ram_write}, 32'd0);
      chk_eq("drop_overrun", {31'd0, overrun}, 32'd1);
      ack = 2'b01;
      tick();
      ack = 2'b00;
      chk_eq("ack0_clears", {30'd0, buf_full}, 32'd2);
      send_sample(16'hBEEF);
      send_sample(16'hCAFE);
      chk_eq("resume_write", {31'd0, ram_write}, 32'd1);
      chk_eq("resume_addr", {23'd0, ram_address}, 32'd0);
      chk_eq("resume_data", ram_writedata, 32'hCAFE_BEEF);
      chk_eq("overrun_sticky", {31'd0, overrun}, 32'd1);
      ack = 2'b01;
      tick();
      ack = 2'b00;
      chk_eq("ack_on_zero", {30'd0, buf_full}, 32'd2);
      clear_overrun = 1'b1;
      tick();
      clear_overrun = 1'b0;
      chk_eq("overrun_cleared", {31'd0, overrun}, 32'd0);

      // Ack colliding with the set of the same bit
      ack = 2'b10;
      tick();
      ack = 2'b00;
      chk_eq("ack1_clears", {30'd0, buf_full}, 32'd0);
      fill_words("refill_half0", 1, 255);
      fill_words("refill_half1", 256, 510);
      send_sample(16'h0A0A);
      ack = 2'b10;
      send_sample(16'h0B0B);
      ack = 2'b00;
      chk_eq("collide_write_addr", {23'd0, ram_address}, 32'd511);
      chk_eq("set_wins_over_ack", {30'd0, buf_full}, 32'd3);

      // Clear and new drop in the same cycle
      send_sample(16'h1111);
      send_sample(16'h2222);
      chk_eq("drop2_overrun", {31'd0, overrun}, 32'd1);
      send_sample(16'h3333);
      clear_overrun = 1'b1;
      send_sample(16'h4444);
      clear_overrun = 1'b0;
      chk_eq("drop_beats_clear", {31'd0, overrun}, 32'd1);

      // Reset between two samples of a pair
      do_reset();
      enable = 1'b1;
      tick();
      send_sample(16'hDEAD);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_outputs("mid_reset");
      tick();
      send_sample(16'h00A1);
      send_sample(16'h00B2);
      chk_eq("post_reset_write", {31'd0, ram_write}, 32'd1);
      chk_eq("post_reset_addr", {23'd0, ram_address}, 32'd0);
      chk_eq("post_reset_data", ram_writedata, 32'h00B2_00A1);

      // Flush of a lone low sample
      do_reset();
      send_sample(16'h7777);
      chk_eq("idle_ignores", {30'd0, ram_write, overrun}, 32'd0);
      enable = 1'b1;
      tick();
      send_sample(16'h1111);
      send_sample(16'h2222);
      chk_eq("flush_pair_data", ram_writedata, 32'h2222_1111);
      send_sample(16'h3333);
      enable = 1'b0;
      tick();
      chk_eq("flush_not_yet", {31'd0, ram_write}, 32'd0);
      tick();
      chk_eq("flush_write", {31'd0, ram_write}, 32'd1);
      chk_eq("flush_addr", {23'd0, ram_address}, 32'd1);
      chk_eq("flush_data", ram_writedata, 32'h0000_3333);
      chk_eq("flush_be", {28'd0, ram_byteenable}, 32'h3);
      tick();
      chk_eq("flush_once", {31'd0, ram_write}, 32'd0);
      send_sample(16'h9999);
      send_sample(16'h8888);
      chk_eq("idle_after_flush", {31'd0, ram_write}, 32'd0);
      enable = 1'b1;
      tick();
      send_sample(16'h4444);
      send_sample(16'h5555);
      chk_eq("after_flush_addr", {23'd0, ram_address}, 32'd1);
      chk_eq("after_flush_data", ram_writedata, 32'h5555_4444);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
